// File: rtl/ram8_port.sv
// ram8_port: 8-word register memory with valid/ready request port, registered back-pressured
// read response and a clear sequencer that zeroes every word after reset or on command.
module ram8_port #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  input  logic              clr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              busy
);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;
  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [WIDTH-1:0]  mem [2**ADDR_W];
  logic              wr, rd;
  // a stalled response blocks writes too, keeping request order intact
  assign req_ready = (state == IDLE) && !clr && (!rsp_valid || rsp_ready);
  assign wr        = req_valid && req_ready && req_we;
  assign rd        = req_valid && req_ready && !req_we;
  assign busy      = (state == CLEAR);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt) state <= IDLE;
    end else if (clr) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end
  // storage is deliberately unreset; the clear sequence defines its contents
  always_ff @(posedge clk)
    if (state == CLEAR) mem[clr_cnt] <= '0;
    else if (wr) mem[req_addr] <= req_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (rd) rsp_rdata <= mem[req_addr];
      rsp_valid <= rd || (rsp_valid && !rsp_ready);
    end
endmodule

// File: tb/tb_ram8_port.sv
// tb_ram8_port: scoreboard bench for ram8_port with directed scenarios and randomized traffic.
module tb_ram8_port;
  logic        clk = 0, rst_n = 1;
  logic        req_valid = 0, req_we = 0, clr = 0, rsp_ready = 1;
  logic [2:0]  req_addr = 0;
  logic [15:0] req_wdata = 0;
  logic        req_ready, rsp_valid, busy;
  logic [15:0] rsp_rdata;
  int          checks = 0, errors = 0;
  logic [15:0] mem_m [8];
  logic [15:0] q [$];
  int          clr_left = 8;
  logic        pend = 0;
  logic        rnd_done = 0;

  ram8_port dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .clr(clr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a clear takes 8 cycles, reads return the word as it stands when accepted
  always @(negedge clk) begin
    if (!rst_n) begin
      clr_left = 8;
      pend = 0;
      q.delete();
      for (int i = 0; i < 8; i++) mem_m[i] = '0;
    end else begin
      chk("busy", 32'(busy), 32'(clr_left > 0));
      chk("req_ready", 32'(req_ready), 32'(clr_left == 0 && !clr && (!pend || rsp_ready)));
      chk("rsp_valid", 32'(rsp_valid), 32'(pend));
      if (req_valid && req_ready && req_we) mem_m[req_addr] = req_wdata;
      if (req_valid && req_ready && !req_we) q.push_back(mem_m[req_addr]);
      pend = (req_valid && req_ready && !req_we) || (pend && !rsp_ready);
      if (clr_left > 0) clr_left--;
      else if (clr) begin
        clr_left = 8;
        for (int i = 0; i < 8; i++) mem_m[i] = '0;
      end
    end
  end

  // monitor: compares presented response with the scoreboard head, pops on handshake
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(q[0]));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  task automatic req(input logic we, input logic [2:0] a, input logic [15:0] d);
    logic acc;
    int n;
    acc = 0;
    n = 0;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("req_accept", 32'(acc), 32'd1);
    req_valid = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2 rst_n = 0;
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    cycles(2);
    rst_n = 1;
    cycles(8);
    for (int k = 0; k < 8; k++) req(0, 3'(k), 0);
    for (int k = 0; k < 8; k++) req(1, 3'(k), 16'(16'h1111 * k));
    for (int k = 7; k >= 0; k--) req(0, 3'(k), 0);
    cycles(2);
    rsp_ready = 0;
    req(0, 3, 0);
    fork
      begin cycles(4); rsp_ready = 1; end
      req(1, 5, 16'h5555);
    join
    cycles(1);
    clr = 1; req_valid = 1; req_we = 1; req_addr = 2; req_wdata = 16'hBEEF;
    cycles(1);
    clr = 0; req_valid = 0;
    cycles(8);
    req(0, 2, 0);
    req(1, 6, 16'hA5A5);
    req(0, 6, 0);
    cycles(2);
    rsp_ready = 0;
    req(1, 4, 16'h4444);
    req(0, 4, 0);
    clr = 1;
    cycles(1);
    clr = 0;
    cycles(3);
    rst_n = 0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd1);
    cycles(1);
    rst_n = 1;
    rsp_ready = 1;
    cycles(8);
    req(0, 4, 0);
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 15) == 0) begin clr = 1; cycles(1); clr = 0; end
          req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
        end
        rnd_done = 1;
      end
      while (!rnd_done) begin
        @(posedge clk); #1;
        rsp_ready = $urandom_range(0, 3) != 0;
      end
    join
    rsp_ready = 1;
    cycles(4);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
